// File: rtl/jtag_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jtag_pkg : TAP state encodings, instruction opcodes, DR selector |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package jtag_pkg;

  // IEEE 1149.1 reference encoding, so tap_state reads like a standard debugger view
  localparam logic [3:0] c_EX2_DR = 4'h0;
  localparam logic [3:0] c_EX1_DR = 4'h1;
  localparam logic [3:0] c_SH_DR  = 4'h2;
  localparam logic [3:0] c_PA_DR  = 4'h3;
  localparam logic [3:0] c_SEL_IR = 4'h4;
  localparam logic [3:0] c_UPD_DR = 4'h5;
  localparam logic [3:0] c_CAP_DR = 4'h6;
  localparam logic [3:0] c_SEL_DR = 4'h7;
  localparam logic [3:0] c_EX2_IR = 4'h8;
  localparam logic [3:0] c_EX1_IR = 4'h9;
  localparam logic [3:0] c_SH_IR  = 4'hA;
  localparam logic [3:0] c_PA_IR  = 4'hB;
  localparam logic [3:0] c_RTI    = 4'hC;
  localparam logic [3:0] c_UPD_IR = 4'hD;
  localparam logic [3:0] c_CAP_IR = 4'hE;
  localparam logic [3:0] c_TLR    = 4'hF;

  localparam logic [3:0] c_OP_EXTEST = 4'b0000;
  localparam logic [3:0] c_OP_SAMPLE = 4'b0001;
  localparam logic [3:0] c_OP_IDCODE = 4'b0010;
  localparam logic [3:0] c_OP_BYPASS = 4'b1111;

  typedef enum logic [1:0] {
    DR_BSR = 2'd0,
    DR_ID  = 2'd1,
    DR_BYP = 2'd2
  } dr_sel_t;

endpackage
`default_nettype wire

// File: rtl/jtag_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jtag_sync : two-flop synchronizer for TCK/TMS/TDI + TCK edges    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module jtag_sync (
  input  logic ICLK,
  input  logic TRSTn,
  input  logic TCK,
  input  logic TMS,
  input  logic TDI,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic [1:0] r_tck_sync;
  logic [1:0] r_tms_sync;
  logic [1:0] r_tdi_sync;
  logic       r_tck_prev;

  always_ff @(posedge ICLK or negedge TRSTn) begin
    if (!TRSTn) begin
      r_tck_sync <= 2'b00;
      r_tms_sync <= 2'b00;
      r_tdi_sync <= 2'b00;
      r_tck_prev <= 1'b0;
    end else begin
      r_tck_sync <= {r_tck_sync[0], TCK};
      r_tms_sync <= {r_tms_sync[0], TMS};
      r_tdi_sync <= {r_tdi_sync[0], TDI};
      r_tck_prev <= r_tck_sync[1];
    end
  end

  // TMS/TDI share the TCK pipeline depth, so they are valid on the edge pulse
  assign tck_rise = r_tck_sync[1] & ~r_tck_prev;
  assign tck_fall = ~r_tck_sync[1] & r_tck_prev;
  assign tms_s    = r_tms_sync[1];
  assign tdi_s    = r_tdi_sync[1];

endmodule
`default_nettype wire

// File: rtl/tap_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tap_ctrl : oversampled IEEE 1149.1 TAP controller (IR, ID, BYP)  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tap_ctrl
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_5FA3,
  parameter int          IR_W       = 4
) (
  input  logic       ICLK,
  input  logic       TRSTn,
  input  logic       TCK,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       bsr_so,
  output logic       TDO,
  output logic       TDO_en,
  output logic       shift_dr,
  output logic       clk_dr,
  output logic       update_dr,
  output logic       mode,
  output logic       bsr_si,
  output logic [3:0] tap_state
);

  logic            w_tck_rise;
  logic            w_tck_fall;
  logic            w_tms;
  logic            w_tdi;
  logic            w_rise;
  logic [3:0]      w_state_nxt;
  logic [3:0]      r_state;
  logic [IR_W-1:0] r_ir;
  logic [IR_W-1:0] r_ir_shift;
  logic [31:0]     r_id_shift;
  logic            r_bypass;
  dr_sel_t         w_dr_sel;
  logic            w_dr_lsb;
  logic            w_bsr_sel;

  jtag_sync u_sync (
    .ICLK     (ICLK),
    .TRSTn    (TRSTn),
    .TCK      (TCK),
    .TMS      (TMS),
    .TDI      (TDI),
    .tck_rise (w_tck_rise),
    .tck_fall (w_tck_fall),
    .tms_s    (w_tms),
    .tdi_s    (w_tdi)
  );

  // A simultaneous fall would win; cannot occur downstream of the synchronizer
  assign w_rise = w_tck_rise & ~w_tck_fall;

  always_comb begin
    w_state_nxt = c_TLR;
    case (r_state)
      c_TLR:    w_state_nxt = w_tms ? c_TLR    : c_RTI;
      c_RTI:    w_state_nxt = w_tms ? c_SEL_DR : c_RTI;
      c_SEL_DR: w_state_nxt = w_tms ? c_SEL_IR : c_CAP_DR;
      c_CAP_DR: w_state_nxt = w_tms ? c_EX1_DR : c_SH_DR;
      c_SH_DR:  w_state_nxt = w_tms ? c_EX1_DR : c_SH_DR;
      c_EX1_DR: w_state_nxt = w_tms ? c_UPD_DR : c_PA_DR;
      c_PA_DR:  w_state_nxt = w_tms ? c_EX2_DR : c_PA_DR;
      c_EX2_DR: w_state_nxt = w_tms ? c_UPD_DR : c_SH_DR;
      c_UPD_DR: w_state_nxt = w_tms ? c_SEL_DR : c_RTI;
      c_SEL_IR: w_state_nxt = w_tms ? c_TLR    : c_CAP_IR;
      c_CAP_IR: w_state_nxt = w_tms ? c_EX1_IR : c_SH_IR;
      c_SH_IR:  w_state_nxt = w_tms ? c_EX1_IR : c_SH_IR;
      c_EX1_IR: w_state_nxt = w_tms ? c_UPD_IR : c_PA_IR;
      c_PA_IR:  w_state_nxt = w_tms ? c_EX2_IR : c_PA_IR;
      c_EX2_IR: w_state_nxt = w_tms ? c_UPD_IR : c_SH_IR;
      c_UPD_IR: w_state_nxt = w_tms ? c_SEL_DR : c_RTI;
      default:  w_state_nxt = c_TLR;
    endcase
  end

  always_ff @(posedge ICLK or negedge TRSTn) begin
    if (!TRSTn) begin
      r_state <= c_TLR;
    end else if (w_rise) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge ICLK or negedge TRSTn) begin
    if (!TRSTn) begin
      r_ir       <= IR_W'(c_OP_IDCODE);
      r_ir_shift <= IR_W'(1);
    end else begin
      if (r_state == c_TLR) begin
        r_ir <= IR_W'(c_OP_IDCODE);
      end else if (w_tck_fall && (r_state == c_UPD_IR)) begin
        r_ir <= r_ir_shift;
      end
      if (w_rise && (r_state == c_CAP_IR)) begin
        r_ir_shift <= IR_W'(1);
      end else if (w_rise && (r_state == c_SH_IR)) begin
        r_ir_shift <= {w_tdi, r_ir_shift[IR_W-1:1]};
      end
    end
  end

  always_comb begin
    w_dr_sel = DR_BYP;
    if ((r_ir == IR_W'(c_OP_EXTEST)) || (r_ir == IR_W'(c_OP_SAMPLE))) begin
      w_dr_sel = DR_BSR;
    end else if (r_ir == IR_W'(c_OP_IDCODE)) begin
      w_dr_sel = DR_ID;
    end
  end

  assign w_bsr_sel = (w_dr_sel == DR_BSR);

  always_ff @(posedge ICLK or negedge TRSTn) begin
    if (!TRSTn) begin
      r_id_shift <= IDCODE_VAL;
      r_bypass   <= 1'b0;
    end else if (w_rise && (r_state == c_CAP_DR)) begin
      r_id_shift <= IDCODE_VAL;
      r_bypass   <= 1'b0;
    end else if (w_rise && (r_state == c_SH_DR)) begin
      if (w_dr_sel == DR_ID) r_id_shift <= {w_tdi, r_id_shift[31:1]};
      if (w_dr_sel == DR_BYP) r_bypass <= w_tdi;
    end
  end

  always_comb begin
    w_dr_lsb = r_bypass;
    case (w_dr_sel)
      DR_BSR:  w_dr_lsb = bsr_so;
      DR_ID:   w_dr_lsb = r_id_shift[0];
      default: w_dr_lsb = r_bypass;
    endcase
  end

  always_ff @(posedge ICLK or negedge TRSTn) begin
    if (!TRSTn) begin
      TDO    <= 1'b0;
      TDO_en <= 1'b0;
    end else if (w_tck_fall) begin
      TDO_en <= (r_state == c_SH_IR) || (r_state == c_SH_DR);
      if (r_state == c_SH_IR) begin
        TDO <= r_ir_shift[0];
      end else if (r_state == c_SH_DR) begin
        TDO <= w_dr_lsb;
      end
    end
  end

  assign shift_dr  = (r_state == c_SH_DR) && w_bsr_sel;
  assign clk_dr    = w_rise && w_bsr_sel && ((r_state == c_CAP_DR) || (r_state == c_SH_DR));
  assign update_dr = w_tck_fall && w_bsr_sel && (r_state == c_UPD_DR);
  assign mode      = (r_ir == IR_W'(c_OP_EXTEST));
  assign bsr_si    = w_tdi;
  assign tap_state = r_state;

endmodule
`default_nettype wire
